// File: rtl/key_step_counter.sv
// key_step_counter: debounces STEP/LOAD push keys and keeps a wrapping 0..CNT_MAX count for the display converter.
// Each press event fires on the edge its FSM enters PRESSED, so the count register updates on that same edge.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic press_o,
  output logic held_o
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t state_q;
  logic [1:0] sync_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic s;
  logic hit;
  assign s = sync_q[1];
  assign cnt_d = cnt_q + 1'b1;
  assign hit = cnt_d == LAST;
  assign press_o = state_q == PRESS_WAIT && !s && hit;
  assign held_o = state_q == PRESSED || state_q == RELEASE_WAIT;
  // The entry edge counts as the first stable clock, so DEBOUNCE_CYCLES-1 increments complete the window.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      case (state_q)
        IDLE: if (!s) begin
          state_q <= PRESS_WAIT;
          cnt_q   <= '0;
        end
        PRESS_WAIT: if (s) state_q <= IDLE;
        else begin
          cnt_q <= cnt_d;
          if (hit) state_q <= PRESSED;
        end
        PRESSED: if (s) begin
          state_q <= RELEASE_WAIT;
          cnt_q   <= '0;
        end
        RELEASE_WAIT: if (!s) state_q <= PRESSED;
        else begin
          cnt_q <= cnt_d;
          if (hit) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

module key_step_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_MAX = 15
) (
  input  logic       MAX10_CLK1_50,
  input  logic       RESET_N,
  input  logic       STEP_N,
  input  logic       LOAD_N,
  input  logic       DIR,
  input  logic [3:0] LOAD_VAL,
  output logic [3:0] VALUE,
  output logic       UPDATE,
  output logic       KEY_HELD
);
  localparam logic [3:0] MAX = 4'(CNT_MAX);
  logic step_evt, load_evt, step_held, load_held;
  logic [3:0] value_q, value_d;
  logic update_q;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk_i(MAX10_CLK1_50), .rst_n_i(RESET_N), .key_n_i(STEP_N), .press_o(step_evt), .held_o(step_held)
  );
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk_i(MAX10_CLK1_50), .rst_n_i(RESET_N), .key_n_i(LOAD_N), .press_o(load_evt), .held_o(load_held)
  );
  // LOAD takes priority; a simultaneous STEP event is dropped.
  always_comb begin
    value_d = load_evt ? (LOAD_VAL > MAX ? MAX : LOAD_VAL)
            : !step_evt ? value_q
            : DIR ? (value_q == MAX ? 4'd0 : value_q + 4'd1)
            : (value_q == 4'd0 ? MAX : value_q - 4'd1);
  end
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      value_q  <= '0;
      update_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      update_q <= value_d != value_q;
    end
  end
  assign VALUE = value_q;
  assign UPDATE = update_q;
  assign KEY_HELD = step_held | load_held;
endmodule

// File: tb/tb_key_step_counter.sv
// tb_key_step_counter: two counters (CNT_MAX 15 and 9) share one stimulus stream and are checked every cycle
// against a model that accepts a key change after DEBOUNCE_CYCLES consecutive clocks of the new synced level.
module tb_key_step_counter;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic step_n = 1'b1;
  logic load_n = 1'b1;
  logic dir = 1'b1;
  logic [3:0] load_val = 4'd0;
  logic [3:0] val0, val1;
  logic upd0, upd1, held0, held1;
  int vectors = 0;
  int miscompares = 0;
  int pulses0 = 0;
  bit sd1[2], sd2[2], deb[2];
  int run[2];
  int mv[2];
  bit mu[2];
  int mmax[2] = '{15, 9};

  always #5 clk = ~clk;

  key_step_counter #(.DEBOUNCE_CYCLES(D), .CNT_MAX(15)) u0 (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .STEP_N(step_n), .LOAD_N(load_n), .DIR(dir),
    .LOAD_VAL(load_val), .VALUE(val0), .UPDATE(upd0), .KEY_HELD(held0)
  );
  key_step_counter #(.DEBOUNCE_CYCLES(D), .CNT_MAX(9)) u1 (
    .MAX10_CLK1_50(clk), .RESET_N(rst_n), .STEP_N(step_n), .LOAD_N(load_n), .DIR(dir),
    .LOAD_VAL(load_val), .VALUE(val1), .UPDATE(upd1), .KEY_HELD(held1)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sd1[k] = 1'b1;
      sd2[k] = 1'b1;
      deb[k] = 1'b0;
      run[k] = 0;
      mv[k]  = 0;
      mu[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit ev[2];
    bit raw[2];
    int nv;
    raw[0] = step_n;
    raw[1] = load_n;
    for (int k = 0; k < 2; k++) begin
      ev[k] = 1'b0;
      if (!sd2[k] != deb[k]) begin
        run[k]++;
        if (run[k] == D) begin
          deb[k] = !sd2[k];
          run[k] = 0;
          ev[k]  = deb[k];
        end
      end else run[k] = 0;
      sd2[k] = sd1[k];
      sd1[k] = raw[k];
    end
    for (int i = 0; i < 2; i++) begin
      nv = ev[1] ? (int'(load_val) > mmax[i] ? mmax[i] : int'(load_val))
         : ev[0] ? (dir ? (mv[i] + 1) % (mmax[i] + 1) : (mv[i] + mmax[i]) % (mmax[i] + 1))
         : mv[i];
      mu[i] = nv != mv[i];
      mv[i] = nv;
    end
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmpv(input string tag, input logic [3:0] obs, input int exp);
    cmp(tag, {4'd0, obs}, 8'(exp));
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".val0"}, {4'd0, val0}, 8'(mv[0]));
    cmp({tag, ".val1"}, {4'd0, val1}, 8'(mv[1]));
    cmp({tag, ".upd0"}, {7'd0, upd0}, {7'd0, mu[0]});
    cmp({tag, ".upd1"}, {7'd0, upd1}, {7'd0, mu[1]});
    cmp({tag, ".held0"}, {7'd0, held0}, {7'd0, deb[0] | deb[1]});
    cmp({tag, ".held1"}, {7'd0, held1}, {7'd0, deb[0] | deb[1]});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    if (upd0) pulses0++;
    check_all("cyc");
  endtask

  task automatic press(input bit is_load, input int hold);
    if (is_load) load_n = 1'b0;
    else step_n = 1'b0;
    repeat (hold) tick();
    step_n = 1'b1;
    load_n = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    int p;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    step_n = 1'b0;
    repeat (5) tick();
    cmpv("lat5", val0, 0);
    tick();
    cmpv("lat6", val0, 1);
    cmp("lat6.upd", {7'd0, upd0}, 8'd1);
    repeat (14) tick();
    step_n = 1'b1;
    repeat (8) tick();
    p = pulses0;
    step_n = 1'b0; repeat (2) tick();
    step_n = 1'b1; tick();
    step_n = 1'b0; repeat (2) tick();
    step_n = 1'b1; repeat (10) tick();
    cmpv("bounce.val", val0, 1);
    cmp("bounce.pulses", 8'(pulses0 - p), 8'd0);
    load_val = 4'hF;
    press(1'b1, 8);
    dir = 1'b1;
    press(1'b0, 8);
    cmpv("wrap_up0", val0, 0);
    cmpv("wrap_up1", val1, 0);
    dir = 1'b0;
    press(1'b0, 8);
    cmpv("wrap_dn0", val0, 15);
    cmpv("wrap_dn1", val1, 9);
    load_val = 4'd0;
    press(1'b1, 8);
    dir = 1'b1;
    for (int i = 0; i < 10; i++) press(1'b0, 8);
    cmpv("ten_up0", val0, 10);
    cmpv("ten_up1", val1, 0);
    load_val = 4'hC;
    press(1'b1, 8);
    cmpv("load_c0", val0, 12);
    cmpv("load_c1", val1, 9);
    p = pulses0;
    press(1'b1, 8);
    cmp("load_eq.pulses", 8'(pulses0 - p), 8'd0);
    load_val = 4'd3;
    dir = 1'b1;
    p = pulses0;
    step_n = 1'b0;
    press(1'b1, 8);
    cmpv("both0", val0, 3);
    cmpv("both1", val1, 3);
    cmp("both.pulses", 8'(pulses0 - p), 8'd1);
    p = pulses0;
    press(1'b0, 100);
    cmpv("hold0", val0, 4);
    cmp("hold.pulses", 8'(pulses0 - p), 8'd1);
    step_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    #1 check_all("arst");
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    cmpv("rst_held5", val0, 0);
    tick();
    cmpv("rst_held6", val0, 1);
    step_n = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) step_n = ~step_n;
      if ($urandom_range(9) == 0) load_n = ~load_n;
      dir = 1'($urandom_range(1));
      load_val = 4'($urandom_range(15));
      if ($urandom_range(599) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1 check_all("rrst");
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
